// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg : shared types for the hazard scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    localparam int C_REG_W  = 5;
    localparam int C_WORD_W = 32;

    typedef logic [C_REG_W-1:0]  regbits_t;
    typedef logic [C_WORD_W-1:0] word_t;

    typedef struct packed {
        logic     valid;
        regbits_t rw;
        logic     regwrite;
        logic     memread;
        word_t    data;
    } shadow_entry_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    // $0 is hardwired to zero, so a write to it is never a real producer
    function automatic logic writes_reg(input shadow_entry_t e);
        return e.valid & e.regwrite & (e.rw != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_stall_fsm : load-use stall sequencer and stall/bubble generation
// HAZARD_STATS_EN adds stall_cycles / flush_count.  Rev 1.0
// ---------------------------------------------------------------------------
module hazard_stall_fsm
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_STALL = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pipe_en,
    input  logic        flush,
    input  logic        hz,
    output logic        stall_id,
    output logic        bubble_ex
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    // The hz cycle is the first bubble; STALL covers the remaining LOAD_STALL-1
    localparam logic [1:0] C_CNT_INIT = 2'(LOAD_STALL - 1);

    hz_state_t  r_state;
    logic [1:0] r_cnt;
    logic       w_stall;

    assign w_stall   = !flush && (hz || (r_state == STALL));
    assign stall_id  = w_stall;
    assign bubble_ex = w_stall;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else if (pipe_en) begin
            if (flush) begin
                r_state <= IDLE;
                r_cnt   <= 2'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (hz && (C_CNT_INIT != 2'd0)) begin
                            r_state <= STALL;
                            r_cnt   <= C_CNT_INIT;
                        end
                    end
                    STALL: begin
                        if (r_cnt <= 2'd1) begin
                            r_state <= IDLE;
                            r_cnt   <= 2'd0;
                        end else begin
                            r_cnt <= r_cnt - 2'd1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= 2'd0;
                    end
                endcase
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else if (pipe_en) begin
            if (w_stall && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hazard_scoreboard : shadow EX/MEM/WB write pipeline feeding the forward unit
// HAZARD_STATS_EN adds stall_cycles / flush_count.  Rev 1.0
// ---------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int WORD_W     = 32,
    parameter int LOAD_STALL = 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              pipe_en,
    input  logic              flush,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rw,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [WORD_W-1:0] ex_result,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [REG_W-1:0]  fw_rs,
    output logic [REG_W-1:0]  fw_rt,
    output logic [REG_W-1:0]  rw_mem,
    output logic [REG_W-1:0]  rw_wb,
    output logic              regwrite_mem,
    output logic              regwrite_wb,
    output logic [WORD_W-1:0] mem_data,
    output logic [WORD_W-1:0] wb_data,
    output logic              stall_id,
    output logic              bubble_ex
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    shadow_entry_t r_ex, r_mem, r_wb;
    shadow_entry_t w_ex_next, w_mem_next, w_wb_next;
    logic          w_hz;
    logic          w_unused;

    assign w_unused = &{1'b0, r_wb.memread};

    always_comb begin
        w_wb_next       = r_mem;
        w_wb_next.data  = r_mem.memread ? mem_rdata : r_mem.data;
        w_mem_next      = r_ex;
        w_mem_next.data = ex_result;
        w_ex_next       = '0;
        if (!(bubble_ex || flush)) begin
            w_ex_next.valid    = 1'b1;
            w_ex_next.rw       = id_rw;
            w_ex_next.regwrite = id_regwrite;
            w_ex_next.memread  = id_memread;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (pipe_en) begin
            r_ex  <= w_ex_next;
            r_mem <= w_mem_next;
            r_wb  <= w_wb_next;
        end
    end

    assign w_hz = writes_reg(r_ex) && r_ex.memread &&
                  ((r_ex.rw == id_rs) || (r_ex.rw == id_rt));

    assign fw_rs        = id_rs;
    assign fw_rt        = id_rt;
    assign rw_mem       = r_mem.rw;
    assign regwrite_mem = writes_reg(r_mem);
    assign mem_data     = r_mem.memread ? mem_rdata : r_mem.data;
    assign rw_wb        = r_wb.rw;
    assign regwrite_wb  = writes_reg(r_wb);
    assign wb_data      = r_wb.data;

    hazard_stall_fsm #(
        .LOAD_STALL (LOAD_STALL)
    ) u_stall_fsm (
        .CLK          (CLK),
        .nRST         (nRST),
        .pipe_en      (pipe_en),
        .flush        (flush),
        .hz           (w_hz),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

endmodule
`default_nettype wire
